// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-approach round-robin signal controller with demand latching,
// min/extension/max green, timed yellow, all-red clearance and flash maintenance mode.
module traffic_phase_ctrl #(
    parameter int N_DIR       = 2,
    parameter int GREEN_MIN   = 4,
    parameter int GREEN_MAX   = 10,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 1,
    parameter int CNT_W       = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       tick,
    input  logic [N_DIR-1:0]           car,
    input  logic                       flash,
    output logic [N_DIR-1:0]           green,
    output logic [N_DIR-1:0]           yellow,
    output logic [N_DIR-1:0]           red,
    output logic [$clog2(N_DIR)-1:0]   active_dir
);
    localparam int AW = $clog2(N_DIR);
    localparam logic [CNT_W-1:0] GMIN = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] GMAX = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] YEND = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AEND = CNT_W'(ALLRED_TIME - 1);

    typedef enum logic [1:0] {GREEN, YELLOW, ALLRED, FLASH} state_t;

    state_t            r_state;
    logic [AW-1:0]     r_active;
    logic [AW-1:0]     r_next;
    logic [CNT_W-1:0]  r_timer;
    logic [N_DIR-1:0]  r_demand;
    logic              r_blink;

    state_t            w_state;
    logic [N_DIR-1:0]  w_act_mask;
    logic [N_DIR-1:0]  w_set;
    logic [N_DIR-1:0]  w_clr;
    logic              w_other;
    logic              w_green_done;
    logic [AW-1:0]     w_hi;
    logic [AW-1:0]     w_lo;
    logic              w_hi_v;
    logic [AW-1:0]     w_pick;

    assign w_act_mask   = N_DIR'(1) << r_active;
    assign w_other      = |(r_demand & ~w_act_mask);
    assign w_green_done = (r_timer >= GMIN) && w_other && (!car[r_active] || r_timer >= GMAX);

    assign w_state = flash ? FLASH :
                     r_state == GREEN  ? (w_green_done ? YELLOW : GREEN) :
                     r_state == YELLOW ? ((tick && r_timer == YEND) ? ALLRED : YELLOW) :
                     r_state == ALLRED ? ((tick && r_timer == AEND) ? GREEN : ALLRED) :
                     ALLRED;

    // Round-robin search: lowest demanded index above the active one, else lowest below it.
    always_comb begin
        w_hi   = r_active;
        w_lo   = r_active;
        w_hi_v = 1'b0;
        for (int i = N_DIR - 1; i >= 0; i--) begin
            if (r_demand[i] && AW'(i) > r_active) begin
                w_hi   = AW'(i);
                w_hi_v = 1'b1;
            end
            if (r_demand[i] && AW'(i) < r_active) w_lo = AW'(i);
        end
    end
    assign w_pick = w_hi_v ? w_hi : w_lo;

    assign w_set = car & ~((r_state == GREEN) ? w_act_mask : '0);
    assign w_clr = (r_state == ALLRED && w_state == GREEN) ? (N_DIR'(1) << r_next) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= GREEN;
            r_active <= '0;
            r_next   <= '0;
            r_timer  <= '0;
            r_demand <= '0;
            r_blink  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_timer  <= (w_state != r_state) ? '0 : r_timer + CNT_W'(tick && !(&r_timer));
            r_demand <= (r_demand | w_set) & ~w_clr;
            r_blink  <= r_blink ^ (r_state == FLASH && tick);
            r_next   <= (r_state == GREEN && w_state == YELLOW) ? w_pick :
                        (r_state == FLASH && w_state == ALLRED) ? r_active : r_next;
            r_active <= (r_state == ALLRED && w_state == GREEN) ? r_next : r_active;
        end
    end

    assign green      = (r_state == GREEN) ? w_act_mask : '0;
    assign yellow     = (r_state == YELLOW) ? w_act_mask : '0;
    assign red        = (r_state == FLASH) ? {N_DIR{r_blink}} :
                        (r_state == ALLRED) ? '1 : ~w_act_mask;
    assign active_dir = r_active;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed scoreboard bench for 2- and 4-approach controllers.
module tb_traffic_phase_ctrl;
    localparam int PG = 0, PY = 1, PA = 2, PF = 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       flash;
    logic [1:0] car2;
    logic [3:0] car4;
    logic [1:0] green2, yellow2, red2;
    logic       act2;
    logic [3:0] green4, yellow4, red4;
    logic [1:0] act4;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    always #5 clock = ~clock;

    traffic_phase_ctrl u_dut2 (
        .clock(clock), .reset_n(reset_n), .tick(tick), .car(car2), .flash(flash),
        .green(green2), .yellow(yellow2), .red(red2), .active_dir(act2)
    );

    traffic_phase_ctrl #(.N_DIR(4)) u_dut4 (
        .clock(clock), .reset_n(reset_n), .tick(tick), .car(car4), .flash(flash),
        .green(green4), .yellow(yellow4), .red(red4), .active_dir(act4)
    );

    wire [15:0] obs2 = {2'b0, green2, 2'b0, yellow2, 2'b0, red2, 3'b0, act2};
    wire [15:0] obs4 = {green4, yellow4, red4, 2'b0, act4};

    // Expected lamps for a phase: one-hot on the active approach, red elsewhere.
    function automatic logic [15:0] lamp(input int ph, input int a, input int n, input bit b);
        logic [3:0] all, oh, g, y, r;
        all = 4'((1 << n) - 1);
        oh  = 4'(1 << a);
        g   = (ph == PG) ? oh : 4'b0;
        y   = (ph == PY) ? oh : 4'b0;
        r   = (ph == PF) ? (b ? all : 4'b0) : (ph == PA) ? all : (all & ~oh);
        return {g, y, r, 4'(a)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic pop_cmp(input bit d4);
        logic [15:0] e;
        string       tg;
        e  = exp_q.pop_front();
        tg = tag_q.pop_front();
        chk(tg, d4 ? obs4 : obs2, e);
    endtask

    task automatic expect_now(input bit d4, input int ph, input int a, input string tag);
        exp_q.push_back(lamp(ph, a, d4 ? 4 : 2, 1'b0));
        tag_q.push_back(tag);
        pop_cmp(d4);
    endtask

    task automatic run(input bit d4, input logic [3:0] c, input bit t, input bit f,
                       input int ph, input int a, input bit b, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            car2  = c[1:0];
            car4  = c;
            tick  = t;
            flash = f;
            exp_q.push_back(lamp(ph, a, d4 ? 4 : 2, b));
            tag_q.push_back($sformatf("%s[%0d]", tag, k));
            @(posedge clock);
            #1;
            pop_cmp(d4);
        end
    endtask

    task automatic do_reset();
        car2    = '0;
        car4    = '0;
        flash   = 1'b0;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        car2    = '0;
        car4    = '0;
        tick    = 1'b0;
        flash   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        expect_now(0, PG, 0, "reset_state2");
        expect_now(1, PG, 0, "reset_state4");
        reset_n = 1'b1;
        run(0, 4'b0000, 1, 0, PG, 0, 0, 50, "idle_hold");

        do_reset();
        run(0, 4'b0010, 1, 0, PG, 0, 0, 1, "handover_pulse");
        run(0, 4'b0000, 1, 0, PG, 0, 0, 3, "handover_min_green");
        run(0, 4'b0000, 1, 0, PY, 0, 0, 3, "handover_yellow");
        run(0, 4'b0000, 1, 0, PA, 0, 0, 1, "handover_allred");
        run(0, 4'b0000, 1, 0, PG, 1, 0, 1, "handover_green1");
        chk("handover_demand_cleared", 16'(u_dut2.r_demand), 16'h0);
        run(0, 4'b0000, 1, 0, PG, 1, 0, 6, "handover_hold1");

        do_reset();
        run(0, 4'b0011, 1, 0, PG, 0, 0, 1, "ext_pulse");
        run(0, 4'b0001, 1, 0, PG, 0, 0, 9, "ext_hold");
        run(0, 4'b0001, 1, 0, PY, 0, 0, 1, "max_green_yellow");

        do_reset();
        run(0, 4'b0011, 1, 0, PG, 0, 0, 1, "drop_pulse");
        run(0, 4'b0001, 1, 0, PG, 0, 0, 5, "drop_hold");
        run(0, 4'b0000, 1, 0, PY, 0, 0, 2, "drop_yellow");
        run(0, 4'b0000, 1, 1, PF, 0, 0, 1, "flash_entry");
        run(0, 4'b0000, 1, 1, PF, 0, 1, 1, "flash_blink_on");
        run(0, 4'b0000, 0, 1, PF, 0, 1, 1, "flash_tick_low");
        run(0, 4'b0000, 1, 1, PF, 0, 0, 1, "flash_blink_off");
        run(0, 4'b0000, 1, 1, PF, 0, 1, 1, "flash_blink_on2");
        run(0, 4'b0000, 1, 0, PA, 0, 0, 1, "flash_exit_allred");
        run(0, 4'b0000, 1, 0, PG, 0, 0, 1, "flash_return_green");
        run(0, 4'b0000, 0, 0, PG, 0, 0, 6, "tick_freeze");
        run(0, 4'b0000, 1, 0, PG, 0, 0, 4, "green_resume");
        run(0, 4'b0000, 1, 0, PY, 0, 0, 1, "green_exit_after_freeze");
        run(0, 4'b0001, 1, 0, PY, 0, 0, 2, "yellow_latch");
        run(0, 4'b0000, 1, 0, PA, 0, 0, 1, "pre_reset_allred");
        #2;
        reset_n = 1'b0;
        #1;
        expect_now(0, PG, 0, "async_reset_lamps");
        chk("async_reset_demand", 16'(u_dut2.r_demand), 16'h0);
        #1;
        reset_n = 1'b1;
        run(0, 4'b0000, 1, 0, PG, 0, 0, 8, "post_reset_hold");

        do_reset();
        run(1, 4'b0010, 1, 0, PG, 0, 0, 1, "rr_req1");
        run(1, 4'b0000, 1, 0, PG, 0, 0, 3, "rr_green0");
        run(1, 4'b0000, 1, 0, PY, 0, 0, 1, "rr_yellow0");
        run(1, 4'b1001, 1, 0, PY, 0, 0, 1, "rr_req03");
        run(1, 4'b0000, 1, 0, PY, 0, 0, 1, "rr_yellow0b");
        run(1, 4'b0000, 1, 0, PA, 0, 0, 1, "rr_allred0");
        run(1, 4'b0000, 1, 0, PG, 1, 0, 5, "rr_green1");
        run(1, 4'b0000, 1, 0, PY, 1, 0, 3, "rr_yellow1");
        run(1, 4'b0000, 1, 0, PA, 1, 0, 1, "rr_allred1");
        run(1, 4'b0000, 1, 0, PG, 3, 0, 5, "rr_green3");
        run(1, 4'b0000, 1, 0, PY, 3, 0, 3, "rr_yellow3");
        run(1, 4'b0000, 1, 0, PA, 3, 0, 1, "rr_allred3");
        run(1, 4'b0000, 1, 0, PG, 0, 0, 1, "rr_green0_again");
        chk("rr_demand_cleared", 16'(u_dut4.r_demand), 16'h0);
        run(1, 4'b0000, 1, 0, PG, 0, 0, 6, "rr_hold0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
